// File: rtl/my_pkg.sv
// Shared definitions for the RS5 machine timer: register offsets, IRQ bit
// positions (also used by the CSR bank) and the byte-lane merge helper.
package my_pkg;

  typedef enum logic [4:0] {
    REG_MTIME_L    = 5'h00,
    REG_MTIME_H    = 5'h04,
    REG_MTIMECMP_L = 5'h08,
    REG_MTIMECMP_H = 5'h0C,
    REG_MSIP       = 5'h10,
    REG_PRESCALE   = 5'h14
  } rtcReg_e;

  localparam int unsigned IRQ_MSI = 3;
  localparam int unsigned IRQ_MTI = 7;
  localparam int unsigned IRQ_MEI = 11;

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
    merge_bytes = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merge_bytes[8*b +: 8] = wdata[8*b +: 8];
    end
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync_ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rtc.sv
// Memory-mapped mtime/mtimecmp timer with software and external IRQ sources.
// Define RTC_PRESCALER_EN to divide the mtime tick by (PRESCALE + 1).
module rtc #(
  parameter int PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic [3:0]  we_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        ext_irq_i,
  output logic [31:0] irq_o,
  output logic [63:0] mtime_o
);

  import my_pkg::*;

  logic [63:0]           mtime_q;
  logic [63:0]           mtimecmp_q;
  logic                  msip_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  tick;
  logic                  mti;
  logic                  ext_sync;
  logic [4:0]            offset;
  logic                  wr;
  logic                  rd;
  logic [31:0]           rdata;
  logic [31:0]           irq_next;
  logic                  wr_mtime_l, wr_mtime_h;
  logic                  wr_cmp_l, wr_cmp_h;
  logic                  wr_msip, wr_prescale;

  assign offset  = {addr_i[4:2], 2'b00};
  assign rd      = en_i && (we_i == 4'b0000);
  assign wr      = en_i && (we_i != 4'b0000);
  assign mti     = (mtime_q >= mtimecmp_q);
  assign mtime_o = mtime_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    rdata       = '0;
    wr_mtime_l  = 1'b0;
    wr_mtime_h  = 1'b0;
    wr_cmp_l    = 1'b0;
    wr_cmp_h    = 1'b0;
    wr_msip     = 1'b0;
    wr_prescale = 1'b0;
    case (offset)
      REG_MTIME_L:    begin rdata = mtime_q[31:0];     wr_mtime_l  = wr; end
      REG_MTIME_H:    begin rdata = mtime_q[63:32];    wr_mtime_h  = wr; end
      REG_MTIMECMP_L: begin rdata = mtimecmp_q[31:0];  wr_cmp_l    = wr; end
      REG_MTIMECMP_H: begin rdata = mtimecmp_q[63:32]; wr_cmp_h    = wr; end
      REG_MSIP:       begin rdata = {31'b0, msip_q};   wr_msip     = wr; end
      REG_PRESCALE:   begin rdata = 32'(prescale_q);   wr_prescale = wr; end
      default:        ;
    endcase
  end

`ifdef RTC_PRESCALER_EN
  logic [PRESCALE_W-1:0] pre_cnt_q;

  assign tick = (pre_cnt_q == prescale_q);

  // Reprogramming the divider restarts the count so the new period starts cleanly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale_q <= '0;
      pre_cnt_q  <= '0;
    end else if (wr_prescale) begin
      prescale_q <= PRESCALE_W'(merge_bytes(32'(prescale_q), data_i, we_i));
      pre_cnt_q  <= '0;
    end else if (tick) begin
      pre_cnt_q  <= '0;
    end else begin
      pre_cnt_q  <= pre_cnt_q + PRESCALE_W'(1);
    end
  end
`else
  logic unused_prescale;

  assign tick            = 1'b1;
  assign prescale_q      = '0;
  assign unused_prescale = wr_prescale;
`endif

  logic unused_addr;
  assign unused_addr = &{1'b0, addr_i[1:0]};

  sync_ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ext_irq_i),
    .q     (ext_sync)
  );

  always_comb begin
    irq_next          = '0;
    irq_next[IRQ_MSI] = msip_q;
    irq_next[IRQ_MTI] = mti;
    irq_next[IRQ_MEI] = ext_sync;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      data_o     <= '0;
      irq_o      <= '0;
    end else begin
      irq_o <= irq_next;
      if (rd) data_o <= rdata;

      // A software write to either half wins over the tick; halves never carry.
      if (wr_mtime_l || wr_mtime_h) begin
        if (wr_mtime_l) mtime_q[31:0]  <= merge_bytes(mtime_q[31:0],  data_i, we_i);
        if (wr_mtime_h) mtime_q[63:32] <= merge_bytes(mtime_q[63:32], data_i, we_i);
      end else if (tick) begin
        mtime_q <= mtime_q + 64'd1;
      end

      if (wr_cmp_l) mtimecmp_q[31:0]  <= merge_bytes(mtimecmp_q[31:0],  data_i, we_i);
      if (wr_cmp_h) mtimecmp_q[63:32] <= merge_bytes(mtimecmp_q[63:32], data_i, we_i);
      if (wr_msip && we_i[0]) msip_q <= data_i[0];
    end
  end

endmodule
